// File: rtl/sevseg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sevseg_arbiter
//  Purpose  : Shares one 4-digit seven-segment display among NUM_REQ
//             requesters. Owners are granted round-robin. Each owner keeps
//             the display for DWELL_TICKS prescaled ticks. The owner's
//             16-bit value is forwarded to the downstream segment driver as
//             byte1 (high) / byte0 (low).
//  Ports    : clk    - system clock
//             rst    - synchronous, active-high reset
//             req    - per-requester level-sensitive display request
//             data   - requester i value in data[16*i+15:16*i]
//             grant  - one-hot current owner, all zero when idle
//             byte0  - low byte of owner value
//             byte1  - high byte of owner value
//             idle   - high when nobody owns the display
//             owner  - index of current owner, holds last owner while idle
//  Revision : 1.0 - initial release
// ============================================================================
module sevseg_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TICK_DIV    = 100000,
   parameter int DWELL_TICKS = 2000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [16*NUM_REQ-1:0]        data,
   output logic [NUM_REQ-1:0]           grant,
   output logic [7:0]                   byte0,
   output logic [7:0]                   byte1,
   output logic                         idle,
   output logic [$clog2(NUM_REQ)-1:0]   owner
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int PW = $clog2(TICK_DIV + 1);
   localparam int DW = $clog2(DWELL_TICKS + 1);

   localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] C_DWELL_LAST = DW'(DWELL_TICKS - 1);
   localparam logic [OW:0]   C_NUM_REQ    = (OW + 1)'(NUM_REQ);
   localparam logic [OW-1:0] C_LAST_IDX   = OW'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   state_t               state_q,      state_d;
   logic [NUM_REQ-1:0]   grant_q,      grant_d;
   logic [OW-1:0]        owner_q,      owner_d;
   logic [OW-1:0]        last_owner_q, last_owner_d;
   logic                 idle_q,       idle_d;
   logic [15:0]          value_q,      value_d;
   logic [PW-1:0]        presc_q,      presc_d;
   logic [DW-1:0]        dwell_q,      dwell_d;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   function automatic logic [15:0] slice_of(input logic [16*NUM_REQ-1:0] d,
                                            input logic [OW-1:0]         idx);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (idx == OW'(i)) r = d[16*i +: 16];
      end
      return r;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot_of(input logic [OW-1:0] idx);
      logic [NUM_REQ-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         r[i] = (idx == OW'(i));
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Round-robin search starting just after the last granted index.
   // While an owner holds the display last_owner_q equals owner_q, so the
   // owner itself is the final candidate: on release its req is low and it
   // drops out naturally, on expiry it is only picked if nobody else asks.
   // ------------------------------------------------------------------------
   logic          found;
   logic [OW-1:0] found_idx;
   logic [OW:0]   pos;

   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      pos       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, last_owner_q} + (OW + 1)'(1) + (OW + 1)'(k);
         if (pos >= C_NUM_REQ) pos = pos - C_NUM_REQ;
         if (!found && req[pos[OW-1:0]]) begin
            found     = 1'b1;
            found_idx = pos[OW-1:0];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Prescaler tick and dwell expiry
   // ------------------------------------------------------------------------
   logic        tick;
   logic        expiry;
   logic        owner_req;
   logic [15:0] owner_data;

   always_comb begin
      tick       = (presc_q == C_PRESC_LAST);
      expiry     = tick && (dwell_q == C_DWELL_LAST);
      owner_req  = req[owner_q];
      owner_data = slice_of(data, owner_q);
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   logic take_grant;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      idle_d       = idle_q;
      value_d      = value_q;
      presc_d      = tick ? '0 : presc_q + PW'(1);
      dwell_d      = dwell_q;
      take_grant   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (found) take_grant = 1'b1;
         end
         ST_SHOW: begin
            if (!owner_req) begin
               // Release takes priority over a simultaneous expiry.
               if (found) begin
                  take_grant = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  idle_d  = 1'b1;
               end
            end else if (expiry) begin
               if (found && (found_idx != owner_q)) begin
                  take_grant = 1'b1;
               end else begin
                  // Sole requester: keep ownership and start a fresh dwell.
                  dwell_d = '0;
                  value_d = owner_data;
               end
            end else begin
               value_d = owner_data;
               if (tick) dwell_d = dwell_q + DW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Every new grant updates grant, owner and the display value together
      // and restarts the dwell timing so each dwell has the full length.
      if (take_grant) begin
         state_d      = ST_SHOW;
         grant_d      = onehot_of(found_idx);
         owner_d      = found_idx;
         last_owner_d = found_idx;
         idle_d       = 1'b0;
         value_d      = slice_of(data, found_idx);
         presc_d      = '0;
         dwell_d      = '0;
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         last_owner_q <= C_LAST_IDX;
         idle_q       <= 1'b1;
         value_q      <= '0;
         presc_q      <= '0;
         dwell_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         idle_q       <= idle_d;
         value_q      <= value_d;
         presc_q      <= presc_d;
         dwell_q      <= dwell_d;
      end
   end

   assign grant = grant_q;
   assign owner = owner_q;
   assign idle  = idle_q;
   assign byte0 = value_q[7:0];
   assign byte1 = value_q[15:8];

endmodule
`default_nettype wire

// File: tb/tb_sevseg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevseg_arbiter
//  Purpose  : Self-checking bench for sevseg_arbiter with TICK_DIV=4,
//             DWELL_TICKS=3, NUM_REQ=4 (one dwell = 12 clock cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sevseg_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int TICK_DIV    = 4;
   localparam int DWELL_TICKS = 3;
   localparam int DWELL_CYC   = TICK_DIV * DWELL_TICKS;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] data;
   logic [3:0]  grant;
   logic [7:0]  byte0;
   logic [7:0]  byte1;
   logic        idle;
   logic [1:0]  owner;

   int n_checks;
   int n_fail;

   sevseg_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .TICK_DIV    (TICK_DIV),
      .DWELL_TICKS (DWELL_TICKS)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .data  (data),
      .grant (grant),
      .byte0 (byte0),
      .byte1 (byte1),
      .idle  (idle),
      .owner (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [63:0] data;
      logic [3:0]  grant;
      logic        idle;
      logic [1:0]  owner;
      logic [15:0] value;
   } vec_t;

   vec_t vecs[17];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [3:0] g, input logic i,
                          input logic [1:0] o, input logic [15:0] v);
      chk({name, ".grant"}, 32'(grant), 32'(g));
      chk({name, ".idle"},  32'(idle),  32'(i));
      chk({name, ".owner"}, 32'(owner), 32'(o));
      chk({name, ".bytes"}, {16'h0, byte1, byte0}, 32'(v));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      step();
      rst = 1'b0;
   endtask

   localparam logic [63:0] D_A = {16'hC0DE, 16'hBEEF, 16'h1234, 16'hA5A5};
   localparam logic [63:0] D_B = {16'hC0DE, 16'hBEEF, 16'h5678, 16'hA5A5};
   localparam logic [63:0] D_C = {16'hC0DE, 16'h1111, 16'h1234, 16'hA5A5};
   localparam logic [63:0] D_R = {16'h4003, 16'h3002, 16'h2001, 16'h1000};

   initial begin
      logic [1:0]  seq[4];
      logic [3:0]  oh;
      logic [15:0] dv;

      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      req      = 4'b0000;
      data     = D_A;

      //              rst   req      data  grant    idle  owner  value
      vecs[0]  = '{1'b1, 4'b0000, D_A, 4'b0000, 1'b1, 2'd0, 16'h0000};
      vecs[1]  = '{1'b0, 4'b0000, D_A, 4'b0000, 1'b1, 2'd0, 16'h0000};
      vecs[2]  = '{1'b0, 4'b0100, D_A, 4'b0100, 1'b0, 2'd2, 16'hBEEF};
      vecs[3]  = '{1'b0, 4'b0100, D_A, 4'b0100, 1'b0, 2'd2, 16'hBEEF};
      vecs[4]  = '{1'b0, 4'b0000, D_A, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
      vecs[5]  = '{1'b0, 4'b0000, D_C, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
      vecs[6]  = '{1'b1, 4'b0000, D_A, 4'b0000, 1'b1, 2'd0, 16'h0000};
      vecs[7]  = '{1'b0, 4'b0010, D_A, 4'b0010, 1'b0, 2'd1, 16'h1234};
      vecs[8]  = '{1'b0, 4'b0010, D_B, 4'b0010, 1'b0, 2'd1, 16'h5678};
      vecs[9]  = '{1'b0, 4'b0110, D_B, 4'b0010, 1'b0, 2'd1, 16'h5678};
      vecs[10] = '{1'b0, 4'b0100, D_B, 4'b0100, 1'b0, 2'd2, 16'hBEEF};
      vecs[11] = '{1'b0, 4'b0000, D_B, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
      vecs[12] = '{1'b0, 4'b1000, D_B, 4'b1000, 1'b0, 2'd3, 16'hC0DE};
      vecs[13] = '{1'b0, 4'b1001, D_B, 4'b1000, 1'b0, 2'd3, 16'hC0DE};
      vecs[14] = '{1'b1, 4'b1111, D_B, 4'b0000, 1'b1, 2'd0, 16'h0000};
      vecs[15] = '{1'b0, 4'b1111, D_B, 4'b0001, 1'b0, 2'd0, 16'hA5A5};
      vecs[16] = '{1'b0, 4'b0000, D_B, 4'b0000, 1'b1, 2'd0, 16'hA5A5};

      for (int v = 0; v < 17; v++) begin
         rst  = vecs[v].rst;
         req  = vecs[v].req;
         data = vecs[v].data;
         step();
         chk_all($sformatf("vec%0d", v), vecs[v].grant, vecs[v].idle,
                 vecs[v].owner, vecs[v].value);
      end

      // Rotation with req=1011: owners 0,1,3,0, each exactly one dwell.
      seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3; seq[3] = 2'd0;
      data = D_R;
      do_reset();
      req = 4'b1011;
      for (int s = 0; s < 4; s++) begin
         step();
         oh = 4'b0001 << seq[s];
         dv = D_R[16*seq[s] +: 16];
         chk_all($sformatf("rot%0d", s), oh, 1'b0, seq[s], dv);
         if (s < 3) begin
            for (int c = 1; c < DWELL_CYC; c++) begin
               step();
               chk($sformatf("rot%0d.hold%0d", s, c), 32'(grant), 32'(oh));
            end
         end
      end

      // Sole requester 1: re-arms every dwell, no grant glitches; a late
      // request from 3 waits for the next dwell boundary (cycle 48).
      do_reset();
      req = 4'b0010;
      step();
      chk_all("solo.start", 4'b0010, 1'b0, 2'd1, 16'h2001);
      for (int c = 1; c <= 40; c++) begin
         step();
         chk($sformatf("solo.c%0d", c), 32'(grant), 32'h2);
      end
      req = 4'b1010;
      for (int c = 41; c < 4 * DWELL_CYC; c++) begin
         step();
         chk($sformatf("solo.wait%0d", c), 32'(grant), 32'h2);
      end
      step();
      chk_all("solo.switch", 4'b1000, 1'b0, 2'd3, 16'h4003);

      // Owner 0 drops its request at cycle 5 while requester 2 waits.
      do_reset();
      req = 4'b0101;
      step();
      chk_all("drop.start", 4'b0001, 1'b0, 2'd0, 16'h1000);
      for (int c = 1; c <= 5; c++) begin
         step();
         chk($sformatf("drop.c%0d", c), 32'(grant), 32'h1);
      end
      req = 4'b0100;
      step();
      chk_all("drop.switch", 4'b0100, 1'b0, 2'd2, 16'h3002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sevseg_arbiter.md
Name: sevseg_arbiter

Overview:
- Shares the 4-digit seven-segment display between NUM_REQ requesters. Each requester supplies a 16-bit value.
- Owners are granted round-robin. Each owner keeps the display for a fixed dwell time, measured in prescaled ticks.
- The owner's value drives byte0/byte1 of the seven-segment driver, which sits directly downstream.
- Typical use: cycling debug values such as PC, status and counters on the board display.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TICK_DIV, 100000, clk cycles per dwell tick; 1 ms at 100 MHz. Must be >= 1.
- DWELL_TICKS, 2000, ticks an owner keeps the display before rotation is considered. Must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester display request; level-sensitive
- data  in  16*NUM_REQ  requester i value in data[16*i+15:16*i]
- grant  out  NUM_REQ  one-hot current owner; all zero when idle
- byte0  out  8  low byte of owner value, to driver byte0
- byte1  out  8  high byte of owner value, to driver byte1
- idle  out  1  high when no owner
- owner  out  clog2(NUM_REQ)  index of current owner; holds last owner while idle

Behaviour:
- Reset (rst wins over everything):
  - grant=0, byte0=0, byte1=0, idle=1, owner=0.
  - Tick prescaler and dwell counter cleared.
  - Internal last-owner pointer set to NUM_REQ-1, so the first search starts at requester 0.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and wraps. The tick pulse is 1 cycle, asserted when the count is TICK_DIV-1.
  - It is cleared whenever a new grant is issued, so every dwell is exactly DWELL_TICKS*TICK_DIV cycles.
- Round-robin search:
  - Scans from (last_owner+1) mod NUM_REQ upward with wrap-around and picks the first index with req high.
  - The scan is purely combinational on current req.
- State IDLE:
  - If any req is high, the searched index becomes owner.
  - On the next edge: grant goes one-hot, idle=0, dwell counter=0, go to SHOW.
  - With no requests, remain in IDLE. byte0/byte1 hold their last values.
- State SHOW:
  - Every cycle, {byte1,byte0} <= owner's data slice, so the display tracks live data with 1-cycle latency.
  - Dwell counter increments on each tick.
  - Release: if req[owner]=0, search excluding owner next edge. If another requester is found, switch directly; otherwise go to IDLE with grant=0 and idle=1.
  - Expiry: when the dwell counter is DWELL_TICKS-1 and a tick occurs, search from owner+1.
    - If a different requester is found, switch to it.
    - If only the owner requests, keep ownership and clear the dwell counter.
  - Release and expiry in the same cycle are handled as release.
- Switch semantics:
  - grant, owner and byte outputs all update on the same edge. byte outputs take the new owner's data sampled at that edge.
  - There is never a cycle with two grant bits set or with byte outputs from a non-owner.
  - last_owner updates on every grant.
- Request-timing corner cases:
  - A requester raising req mid-dwell does not preempt. It waits for expiry or release.
  - A requester whose req pulses only between scans is never granted. No request latching.
- Reset mid-SHOW: next edge gives reset values, and ownership restarts from requester 0.
- Width rules:
  - Dwell counter width is clog2(DWELL_TICKS+1); prescaler width is clog2(TICK_DIV+1).
  - No arithmetic overflow is permitted.

Test Plan (TICK_DIV=4, DWELL_TICKS=3, NUM_REQ=4):
- Reset, then req=0000 → grant=0000, idle=1, byte0=byte1=00. Then req=0100 with data2=16'hBEEF → one cycle later grant=0100, owner=2, byte1=BE, byte0=EF, idle=0.
- req=1011 held with distinct data → owners cycle 0,1,3,0 with each grant lasting exactly 12 cycles. Byte outputs match each owner's data on the grant edge.
- Only req[1] high for 40 cycles → grant stays 0010 throughout, dwell re-arms every 12 cycles, and there are no glitches on grant.
- Owner 0 drops req at cycle 5 of its dwell while req[2]=1 → next edge grant=0100. Owner 0 drops req with no other requests → next edge grant=0000, idle=1, bytes hold last value.
- Owner 1 changes data from 16'h1234 to 16'h5678 mid-dwell → byte1/byte0 become 56/78 one cycle later, and grant is unchanged.
- rst asserted mid-dwell while owner=3 and req=1111 → next edge gives reset values. After release, the first grant goes to requester 0.
